// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: word-addressed instruction RAM, a fixed-latency
// read pipeline and a credit-protected response FIFO, so decode backpressure
// never drops an accepted fetch.
module imem_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_pc,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0]         ram [DEPTH_WORDS];
  logic                accept, pop, push, req_err;
  logic [AW-1:0]       req_word, wr_word;
  logic [CW-1:0]       outstanding_q, fifo_cnt_q;
  logic [LATENCY-1:0]  stg_valid_q, stg_err_q;
  logic [31:0]         stg_pc_q    [LATENCY];
  logic [31:0]         stg_instr_q [LATENCY];
  logic [31:0]         fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]         fifo_instr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_err_q;
  logic [PW-1:0]       wptr_q, rptr_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_word  = req_pc[AW+1:2];
  assign wr_word   = wr_addr[AW+1:2];
  assign req_err   = (req_pc[1:0] != 2'b00) || (req_pc >= BYTE_LIMIT);
  // Credits: every accepted fetch owns a FIFO slot until it is popped.
  assign req_ready = rst_n && !flush && (outstanding_q < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = stg_valid_q[LATENCY-1];
  assign rsp_pc    = fifo_pc_q[rptr_q];
  assign rsp_instr = fifo_instr_q[rptr_q];
  assign rsp_err   = fifo_err_q[rptr_q];

  // Program-load port; out-of-range writes are dropped. Not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < BYTE_LIMIT)) begin
      ram[wr_word] <= wr_data;
    end
  end

  // Pipeline valid bits: cleared by reset and flush, shift every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= '0;
    end else if (flush) begin
      stg_valid_q <= '0;
    end else begin
      stg_valid_q[0] <= accept;
      for (int k = 1; k < LATENCY; k++) begin
        stg_valid_q[k] <= stg_valid_q[k-1];
      end
    end
  end

  // Pipeline payload; RAM is sampled at the accept edge so a same-cycle
  // write to the same word is not observed by this fetch.
  always_ff @(posedge clk) begin
    if (accept) begin
      stg_pc_q[0]    <= req_pc;
      stg_err_q[0]   <= req_err;
      stg_instr_q[0] <= req_err ? NOP_WORD : ram[req_word];
    end
    for (int k = 1; k < LATENCY; k++) begin
      stg_pc_q[k]    <= stg_pc_q[k-1];
      stg_err_q[k]   <= stg_err_q[k-1];
      stg_instr_q[k] <= stg_instr_q[k-1];
    end
  end

  // Response FIFO and outstanding-credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
      fifo_err_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      if (push) begin
        fifo_pc_q[wptr_q]    <= stg_pc_q[LATENCY-1];
        fifo_instr_q[wptr_q] <= stg_instr_q[LATENCY-1];
        fifo_err_q[wptr_q]   <= stg_err_q[LATENCY-1];
        wptr_q               <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CW'(1);
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - CW'(1);
      end
      if (accept && !pop) begin
        outstanding_q <= outstanding_q + CW'(1);
      end else if (!accept && pop) begin
        outstanding_q <= outstanding_q - CW'(1);
      end
    end
  end

endmodule
